// File: rtl/frame_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_cfg_pkg
// Purpose  : Shared constants for the frame configuration controller: the
//            sync word, command opcodes, header field positions and the
//            controller state encoding.
// Ports    : none (package)
// Options  : CONFIG_CHECKSUM_EN enables the CHK state in the controller.
// Revision : 1.0 - initial release
// ============================================================================
package frame_cfg_pkg;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;
  localparam logic [7:0]  OP_WRITE  = 8'h01;
  localparam logic [7:0]  OP_END    = 8'h02;

  // Header layout: opcode [31:24], column [15:8], frame [7:0].
  localparam int FIELD_W = 8;
  localparam int OPC_LSB = 24;
  localparam int COL_LSB = 8;
  localparam int FRM_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_DATA   = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_CHK    = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_strobe_decoder.sv
`default_nettype none
// ============================================================================
// Module   : frame_strobe_decoder
// Purpose  : Combinational one-hot decode of a {column, frame} address into
//            the flat FrameStrobe vector (bit col*MaxFramesPerCol+frame).
// Ports    : col    in  8   latched column address
//            frame  in  8   latched frame address
//            en     in  1   produce a strobe this cycle
//            strobe out MaxFramesPerCol*NumColumns  one-hot (or all zero)
// Revision : 1.0 - initial release
// ============================================================================
module frame_strobe_decoder #(
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 8
) (
  input  logic [7:0]                              col,
  input  logic [7:0]                              frame,
  input  logic                                    en,
  output logic [MaxFramesPerCol*NumColumns-1:0]   strobe
);

  for (genvar c = 0; c < NumColumns; c++) begin : g_col
    for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_frm
      assign strobe[c*MaxFramesPerCol+f] = en && (col == 8'(c)) && (frame == 8'(f));
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_config_ctrl
// Purpose  : Hunts for the sync word, parses frame-write headers, assembles a
//            frame column in FrameData and fires a registered one-hot
//            FrameStrobe for the addressed frame latches.
// Ports    : CLK         in   1    clock
//            resetn      in   1    asynchronous active-low reset
//            in_data     in   32   configuration word
//            in_valid    in   1    in_data valid
//            in_ready    out  1    word accepted when in_valid && in_ready
//            FrameData   out  FrameBitsPerRow*NumRows   assembled frame
//            FrameStrobe out  MaxFramesPerCol*NumColumns one-hot latch strobe
//            busy        out  1    session active (sync seen, no END yet)
//            done        out  1    sticky, END received cleanly
//            err         out  1    sticky, protocol error
// Options  : CONFIG_CHECKSUM_EN - rotate-xor checksum over header/data words,
//            verified by one extra word after OP_END.
// Revision : 1.0 - initial release
// ============================================================================
module frame_config_ctrl
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 4,
  parameter int NumColumns      = 8
) (
  input  logic                                    CLK,
  input  logic                                    resetn,
  input  logic [31:0]                             in_data,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic [FrameBitsPerRow*NumRows-1:0]      FrameData,
  output logic [MaxFramesPerCol*NumColumns-1:0]   FrameStrobe,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err
);

  localparam int                ROW_W    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(NumRows - 1);
  localparam logic [8:0]        COL_LIM  = 9'(NumColumns);
  localparam logic [8:0]        FRM_LIM  = 9'(MaxFramesPerCol);
  localparam int                STROBE_W = MaxFramesPerCol * NumColumns;

  state_t                state;
  logic [ROW_W-1:0]      row;
  logic [7:0]            addr_col;
  logic [7:0]            addr_frame;

  logic                  accept;
  logic [7:0]            hdr_op;
  logic [7:0]            hdr_col;
  logic [7:0]            hdr_frm;
  logic                  hdr_addr_ok;
  logic                  last_word;
  logic [STROBE_W-1:0]   strobe_next;

  assign accept      = in_valid && in_ready;
  assign hdr_op      = in_data[OPC_LSB +: FIELD_W];
  assign hdr_col     = in_data[COL_LSB +: FIELD_W];
  assign hdr_frm     = in_data[FRM_LSB +: FIELD_W];
  assign hdr_addr_ok = ({1'b0, hdr_col} < COL_LIM) && ({1'b0, hdr_frm} < FRM_LIM);
  // The strobe is decoded while the final row is being accepted and then
  // registered, so it appears in the cycle after that word.
  assign last_word   = (state == S_DATA) && accept && (row == LAST_ROW);

`ifdef CONFIG_CHECKSUM_EN
  logic [31:0] chk;
  logic [31:0] chk_next;
  assign chk_next = {chk[30:0], chk[31]} ^ in_data;
`endif

  frame_strobe_decoder #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .NumColumns      (NumColumns)
  ) u_decoder (
    .col    (addr_col),
    .frame  (addr_frame),
    .en     (last_word),
    .strobe (strobe_next)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      row         <= '0;
      addr_col    <= '0;
      addr_frame  <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef CONFIG_CHECKSUM_EN
      chk         <= '0;
`endif
    end else begin
      in_ready    <= 1'b1;
      FrameStrobe <= strobe_next;
      case (state)
        S_IDLE: begin
          if (accept && (in_data == SYNC_WORD)) begin
            state <= S_HDR;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
`ifdef CONFIG_CHECKSUM_EN
            chk   <= '0;
`endif
          end
        end

        S_HDR: begin
          if (accept) begin
`ifdef CONFIG_CHECKSUM_EN
            chk <= chk_next;
`endif
            if ((hdr_op == OP_WRITE) && hdr_addr_ok) begin
              addr_col   <= hdr_col;
              addr_frame <= hdr_frm;
              row        <= '0;
              state      <= S_DATA;
            end else if (hdr_op == OP_END) begin
`ifdef CONFIG_CHECKSUM_EN
              state <= S_CHK;
`else
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
`endif
            end else begin
              // Bad address or unknown opcode (including a repeated sync).
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
`ifdef CONFIG_CHECKSUM_EN
            chk <= chk_next;
`endif
            for (int r = 0; r < NumRows; r++) begin
              if (row == ROW_W'(r)) begin
                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= in_data;
              end
            end
            if (row == LAST_ROW) begin
              state    <= S_STROBE;
              in_ready <= 1'b0;
            end else begin
              row <= row + 1'b1;
            end
          end
        end

        // Two stall cycles keep FrameData stable around the strobe.
        S_STROBE: begin
          state    <= S_HOLD;
          in_ready <= 1'b0;
        end

        S_HOLD: begin
          state <= S_HDR;
        end

        S_CHK: begin
`ifdef CONFIG_CHECKSUM_EN
          if (accept) begin
            if (in_data == chk) done <= 1'b1;
            else                err  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_config_ctrl
// Purpose  : Self-checking bench for frame_config_ctrl. Stimulus tasks push
//            expected strobe/done/err events into a queue; a monitor on the
//            falling edge pops and compares them as the DUT produces them.
// Options  : CONFIG_CHECKSUM_EN adds the checksum word after END.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_config_ctrl;

  localparam int MF  = 20;
  localparam int FB  = 32;
  localparam int NR  = 4;
  localparam int NC  = 8;
  localparam int SW  = FB * NR;
  localparam int STW = MF * NC;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  // kind: 1 = strobe, 2 = done rising, 3 = err rising
  typedef struct {
    int            kind;
    int            idx;
    logic [SW-1:0] data;
  } ev_t;

  logic            CLK = 1'b0;
  logic            resetn;
  logic [31:0]     in_data;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   FrameData;
  logic [STW-1:0]  FrameStrobe;
  logic            busy;
  logic            done;
  logic            err;

  int              tests = 0;
  int              fails = 0;
  ev_t             q[$];
  logic [31:0]     chk_m;
  logic [SW-1:0]   fd_model = '0;

  always #5 CLK = ~CLK;

  frame_config_ctrl #(
    .MaxFramesPerCol (MF),
    .FrameBitsPerRow (FB),
    .NumRows         (NR),
    .NumColumns      (NC)
  ) dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          prev_done = 1'b0;
  logic          prev_err  = 1'b0;
  logic          hold_chk  = 1'b0;
  logic [SW-1:0] strobe_data;

  task automatic pop_expect(input int kind, input int idx, input logic [SW-1:0] data);
    ev_t e;
    if (q.size() == 0) begin
      check("unexpected_event", kind, 0);
      return;
    end
    e = q.pop_front();
    check("event_kind", kind, e.kind);
    if (kind == 1 && e.kind == 1) begin
      check("strobe_index", idx, e.idx);
      check("strobe_data", data, e.data);
    end
  endtask

  always @(negedge CLK) begin
    if (resetn) begin
      if (FrameStrobe != '0) begin
        int idx;
        idx = -1;
        for (int i = 0; i < STW; i++) if (FrameStrobe[i]) idx = i;
        check("strobe_onehot", $onehot(FrameStrobe), 1);
        pop_expect(1, idx, FrameData);
        strobe_data = FrameData;
        hold_chk    = 1'b1;
      end else if (hold_chk) begin
        check("data_hold_after_strobe", FrameData, strobe_data);
        hold_chk = 1'b0;
      end
      if (done && !prev_done) pop_expect(2, 0, '0);
      if (err && !prev_err)   pop_expect(3, 0, '0);
    end else begin
      hold_chk = 1'b0;
    end
    prev_done = done;
    prev_err  = err;
  end

  // ---------------- driver ----------------
  // mode 0: back-to-back, 1: random idle cycles, 2: idle cycle before every word
  task automatic send(input logic [31:0] w, input int mode);
    int n;
    if (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0)) begin
      @(negedge CLK);
      in_valid = 1'b0;
      in_data  = $urandom;
    end
    @(negedge CLK);
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) check("handshake_timeout", 0, 1);
    else @(posedge CLK);
  endtask

  task automatic idle();
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic chk_upd(input logic [31:0] w);
    chk_m = {chk_m[30:0], chk_m[31]} ^ w;
  endtask

  function automatic logic [SW-1:0] rand_frame();
    logic [SW-1:0] d;
    for (int r = 0; r < NR; r++) d[r*FB +: FB] = $urandom;
    return d;
  endfunction

  task automatic do_sync(input int mode);
    send(SYNC, mode);
    chk_m = '0;
  endtask

  task automatic do_write(input int col, input int frm, input int mode, input logic [SW-1:0] d);
    logic [31:0] w;
    ev_t         e;
    int          n;
    w = {8'h01, 8'($urandom), 8'(col), 8'(frm)};
    e.idx  = col * MF + frm;
    e.data = d;
    if (col >= NC || frm >= MF) begin
      e.kind = 3;
      q.push_back(e);
      send(w, mode);
      return;
    end
    e.kind = 1;
    q.push_back(e);
    send(w, mode);
    chk_upd(w);
    for (int r = 0; r < NR; r++) begin
      send(d[r*FB +: FB], mode);
      chk_upd(d[r*FB +: FB]);
    end
    fd_model = d;
    @(negedge CLK);
    in_valid = 1'b0;
    check("busy_during_frame", busy, 1);
    n = 0;
    while (!in_ready && n < 10) begin
      n++;
      @(negedge CLK);
    end
    check("stall_cycles", n, 2);
  endtask

  task automatic do_end(input bit flip, input int mode);
    ev_t         e;
    logic [31:0] w;
    w = {8'h02, 24'($urandom)};
`ifdef CONFIG_CHECKSUM_EN
    e.kind = flip ? 3 : 2;
    q.push_back(e);
    send(w, mode);
    chk_upd(w);
    send(flip ? (chk_m ^ (32'h1 << $urandom_range(0, 31))) : chk_m, mode);
`else
    e.kind = 2;
    q.push_back(e);
    send(w, mode);
`endif
  endtask

  task automatic do_bad_op(input int mode);
    ev_t        e;
    logic [7:0] op;
    op = 8'($urandom_range(3, 255));
    if ($urandom_range(0, 1) == 0) op = 8'h00;
    e.kind = 3;
    q.push_back(e);
    send({op, 24'($urandom)}, mode);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [SW-1:0] d;
    logic [31:0]   w;
    int            ncmd;
    bit            ended;
    int            r;

    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge CLK);
    check("rst_in_ready", in_ready, 0);
    check("rst_framedata", FrameData, 0);
    check("rst_strobe", FrameStrobe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    resetn = 1'b1;
    @(negedge CLK);
    check("ready_after_release", in_ready, 1);

    // col 0 frame 0 with known words
    do_sync(0);
    d = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    do_write(0, 0, 0, d);
    check("busy_after_sync", busy, 1);

    // last column / last frame, then END
    do_write(7, 19, 0, rand_frame());
    do_end(1'b0, 0);
    idle();
    check("done_after_end", done, 1);
    check("busy_after_end", busy, 0);
    check("err_after_end", err, 0);
    check("data_persist_after_end", FrameData, fd_model);

    // frame 20 out of range, then ignored traffic before the next sync
    do_sync(0);
    do_write(0, 20, 0, '0);
    idle();
    check("err_bad_frame", err, 1);
    check("busy_bad_frame", busy, 0);
    check("ready_in_idle", in_ready, 1);
    send({8'h01, 8'h00, 8'h01, 8'h01}, 0);
    for (int k = 0; k < NR; k++) send(32'h5A5A_0000 + 32'(k), 0);
    idle();
    repeat (3) @(negedge CLK);
    check("ignored_data", FrameData, fd_model);

    // in_valid toggling through DATA
    do_sync(0);
    do_write(3, 5, 2, rand_frame());
    do_end(1'b0, 2);
    idle();

    // reset in the cycle the strobe would fire
    do_sync(0);
    send({8'h01, 8'h00, 8'h02, 8'h03}, 0);
    for (int k = 0; k < NR - 1; k++) send($urandom, 0);
    @(negedge CLK);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    @(posedge CLK);
    #1;
    resetn   = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    check("abort_strobe", FrameStrobe, 0);
    check("abort_framedata", FrameData, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 0);
    fd_model = '0;
    resetn = 1'b1;
    @(negedge CLK);
    check("abort_ready_release", in_ready, 1);

`ifdef CONFIG_CHECKSUM_EN
    do_sync(0);
    do_write(1, 2, 0, rand_frame());
    do_end(1'b1, 0);
    idle();
    check("chk_flip_err", err, 1);
    check("chk_flip_done", done, 0);
`endif

    // randomized sessions
    for (int s = 0; s < 15; s++) begin
      repeat ($urandom_range(0, 3)) begin
        w = $urandom;
        if (w == SYNC) w = w ^ 32'h1;
        send(w, 1);
      end
      do_sync(1);
      ended = 1'b0;
      ncmd  = $urandom_range(1, 4);
      for (int c = 0; c < ncmd && !ended; c++) begin
        r = $urandom_range(0, 9);
        if (r < 7) begin
          do_write($urandom_range(0, NC - 1), $urandom_range(0, MF - 1), 1, rand_frame());
        end else if (r == 7) begin
          if ($urandom_range(0, 1) == 0) do_write($urandom_range(NC, 255), $urandom_range(0, MF - 1), 1, '0);
          else                           do_write($urandom_range(0, NC - 1), $urandom_range(MF, 255), 1, '0);
          ended = 1'b1;
        end else begin
          do_bad_op(1);
          ended = 1'b1;
        end
      end
      if (!ended) do_end($urandom_range(0, 3) == 0, 1);
      idle();
    end

    repeat (5) @(negedge CLK);
    check("pending_events", q.size(), 0);
    check("final_framedata", FrameData, fd_model);
    check("final_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
